dsc_csc_slice_pipe: RTL

//  Streaming front end of the DSC encoder datapath. Takes raster-order source pixels (R,G,B,optional A)
//  and applies an optional lossless RGB->YCoCg-R transform. Each output pixel carries slice-line and

---
 rtl/dsc_csc_slice_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dsc_csc_slice_pipe.sv
// dsc_csc_slice_pipe: raster pixel front end with optional lossless RGB->YCoCg-R transform and slice/picture tags.
// Two-stage pipeline with a shared advance enable; the control FSM latches configuration per frame.
module dsc_csc_slice_pipe #(
    parameter int BPC_MAX   = 12,
    parameter int HAS_ALPHA = 1,
    parameter int DIM_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cfg_color,
    input  logic               cfg_alpha,
    input  logic [3:0]         cfg_bpc,
    input  logic [DIM_W-1:0]   cfg_pic_w,
    input  logic [DIM_W-1:0]   cfg_pic_h,
    input  logic [DIM_W-1:0]   cfg_slice_w,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BPC_MAX-1:0] in_r,
    input  logic [BPC_MAX-1:0] in_g,
    input  logic [BPC_MAX-1:0] in_b,
    input  logic [BPC_MAX-1:0] in_a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BPC_MAX:0]   out_c0,
    output logic [BPC_MAX:0]   out_c1,
    output logic [BPC_MAX:0]   out_c2,
    output logic [BPC_MAX-1:0] out_a,
    output logic               out_sol,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               done
);
    localparam int W  = BPC_MAX + 2;
    localparam int OW = BPC_MAX + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic                 col, alp;
    logic [3:0]           bpc;
    logic [DIM_W-1:0]     pw, ph, sw, x, y, sx;
    logic                 v1, sol1, eol1, eof1;
    logic signed [W-1:0]  p0, p1, p2;
    logic [BPC_MAX-1:0]   a1, mask, a_in;
    logic signed [W-1:0]  rz, gz, bz, co, t, cg, off;
    logic [OW-1:0]        yv, c1v, c2v;
    logic                 en, acc, x_last, y_last, s_last;

    assign en       = !out_valid || out_ready;
    assign in_ready = (state == RUN) && en;
    assign acc      = in_valid && in_ready;
    assign busy     = state != IDLE;

    // bits at and above the active bit depth are forced to zero
    assign mask = ~({BPC_MAX{1'b1}} << bpc);
    assign rz   = {2'b00, in_r & mask};
    assign gz   = {2'b00, in_g & mask};
    assign bz   = {2'b00, in_b & mask};
    assign a_in = (HAS_ALPHA != 0 && alp) ? (in_a & mask) : '0;

    assign co  = rz - bz;
    assign t   = bz + (co >>> 1);
    assign cg  = gz - t;
    assign off = W'(1) << bpc;
    assign yv  = OW'(p0 + (p2 >>> 1));
    assign c1v = OW'(p1 + off);
    assign c2v = OW'(p2 + off);

    assign x_last = x == pw - 1'b1;
    assign y_last = y == ph - 1'b1;
    assign s_last = sx == sw - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= 1'b0;
            alp   <= 1'b0;
            bpc   <= '0;
            pw    <= '0;
            ph    <= '0;
            sw    <= '0;
            x     <= '0;
            y     <= '0;
            sx    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    col   <= cfg_color;
                    alp   <= cfg_alpha;
                    bpc   <= cfg_bpc;
                    pw    <= cfg_pic_w;
                    ph    <= cfg_pic_h;
                    sw    <= cfg_slice_w;
                    x     <= '0;
                    y     <= '0;
                    sx    <= '0;
                    state <= RUN;
                end
                RUN: if (acc) begin
                    if (x_last) begin
                        x  <= '0;
                        sx <= '0;
                        y  <= y + 1'b1;
                        if (y_last) state <= DRAIN;
                    end else begin
                        x  <= x + 1'b1;
                        sx <= s_last ? '0 : sx + 1'b1;
                    end
                end
                DRAIN: if (!v1 && !out_valid) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            a1        <= '0;
            sol1      <= 1'b0;
            eol1      <= 1'b0;
            eof1      <= 1'b0;
            out_valid <= 1'b0;
            out_c0    <= '0;
            out_c1    <= '0;
            out_c2    <= '0;
            out_a     <= '0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (en) begin
            v1        <= acc;
            p0        <= col ? t : rz;
            p1        <= col ? co : gz;
            p2        <= col ? cg : bz;
            a1        <= a_in;
            sol1      <= sx == '0;
            eol1      <= s_last || x_last;
            eof1      <= x_last && y_last;
            out_valid <= v1;
            out_c0    <= col ? yv : OW'(p0);
            out_c1    <= col ? c1v : OW'(p1);
            out_c2    <= col ? c2v : OW'(p2);
            out_a     <= a1;
            out_sol   <= sol1;
            out_eol   <= eol1;
            out_eof   <= eof1;
        end
    end
endmodule
